// File: rtl/aes_dec_pipe_param.sv
// aes_dec_pipe_param: fully pipelined AES-128/256 inverse cipher with a streamed round-key bank
module aes_inv_round #(
  parameter bit LAST = 1'b0
) (
  input  logic [127:0] din,
  input  logic [127:0] rk,
  output logic [127:0] dout
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // inverse affine map, then GF(2^8) inverse computed as a^254
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y, y2, y3, y6, y12, y15, y240;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y2 = gm(y, y);
    y3 = gm(y2, y);
    y6 = gm(y3, y3);
    y12 = gm(y6, y6);
    y15 = gm(y12, y3);
    y240 = y15;
    for (int i = 0; i < 4; i++) y240 = gm(y240, y240);
    return gm(gm(y240, y12), y2);
  endfunction
  function automatic logic [7:0] bt(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(bt(s, 4*((c-r+4)%4)+r));
    return o;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gm(bt(s, 4*c+r), 8'h0e) ^ gm(bt(s, 4*c+(r+1)%4), 8'h0b) ^
                                gm(bt(s, 4*c+(r+2)%4), 8'h0d) ^ gm(bt(s, 4*c+(r+3)%4), 8'h09);
    return o;
  endfunction
  logic [127:0] ark;
  assign ark = inv_sub_shift(din) ^ rk;
  assign dout = LAST ? ark : inv_mix(ark);
endmodule

module aes_dec_pipe_param #(
  parameter int KEY_LEN = 128,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             rk_valid,
  input  logic [127:0]     rk_data,
  output logic             key_ready,
  output logic             key_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int NR = (KEY_LEN == 256) ? 14 : 10;
  localparam logic [3:0] LAST_RK = 4'(NR);
  if (KEY_LEN != 128 && KEY_LEN != 256) begin : g_bad_key_len
    $error("KEY_LEN must be 128 or 256");
  end
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  state_t state, state_nx;
  logic [127:0] rk [0:NR];
  logic [3:0] rk_cnt;
  logic [NR:0] vld;
  logic [127:0] st [0:NR];
  logic [TAG_W-1:0] tg [0:NR];
  logic [127:0] rnd [1:NR];
  logic pipe_busy, restart, beat, accept;
  always_comb begin
    pipe_busy = |vld;
    restart = key_start & ~pipe_busy;
    beat = (state == LOAD) & rk_valid & ~key_start;
    state_nx = restart ? LOAD : (beat && rk_cnt == LAST_RK) ? READY : state;
    key_ready = state == READY;
    in_ready = (state == READY) & ~key_start;
    accept = in_valid & in_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rk_cnt <= '0;
      key_err <= 1'b0;
    end else begin
      state <= state_nx;
      rk_cnt <= restart ? '0 : beat ? rk_cnt + 4'd1 : rk_cnt;
      key_err <= key_start & pipe_busy;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) for (int i = 0; i <= NR; i++) rk[i] <= '0;
    else if (beat) rk[rk_cnt] <= rk_data;
  end
  // stage registers only advance behind a valid block so idle outputs stay quiet
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i <= NR; i++) begin
        st[i] <= '0;
        tg[i] <= '0;
      end
    end else begin
      vld <= flush ? '0 : {vld[NR-1:0], accept};
      if (accept) begin
        st[0] <= in_data ^ rk[NR];
        tg[0] <= in_tag;
      end
      for (int i = 1; i <= NR; i++)
        if (vld[i-1]) begin
          st[i] <= rnd[i];
          tg[i] <= tg[i-1];
        end
    end
  end
  for (genvar s = 1; s <= NR; s++) begin : g_round
    aes_inv_round #(.LAST(s == NR)) u_round (.din(st[s-1]), .rk(rk[NR-s]), .dout(rnd[s]));
  end
  assign out_valid = vld[NR];
  assign out_data = st[NR];
  assign out_tag = tg[NR];
endmodule

// File: tb/tb_aes_dec_pipe_param.sv
// tb_aes_dec_pipe_param: checks AES-128 and AES-256 decrypt pipes against a forward-cipher reference model
module tb_aes_dec_pipe_param;
  typedef struct {
    logic [127:0] pt;
    logic [3:0] tag;
    int due;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  logic ks [2], rv [2], iv [2], fl [2], kr [2], ke [2], ir [2], ov [2];
  logic [127:0] rd [2], id [2], od [2], cur_pt [2];
  logic [3:0] it [2], ot [2];
  logic [7:0] sbt [256];
  logic [127:0] krk [2][15];
  ent_t sb [2][$];
  bit mready [2], loading [2], merr [2];
  int beats [2];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_pipe_param #(.KEY_LEN(128), .TAG_W(4)) d128 (
    .clk(clk), .rst(rst), .key_start(ks[0]), .rk_valid(rv[0]), .rk_data(rd[0]),
    .key_ready(kr[0]), .key_err(ke[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_tag(it[0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_data(od[0]), .out_tag(ot[0]));
  aes_dec_pipe_param #(.KEY_LEN(256), .TAG_W(4)) d256 (
    .clk(clk), .rst(rst), .key_start(ks[1]), .rk_valid(rv[1]), .rk_data(rd[1]),
    .key_ready(kr[1]), .key_err(ke[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_tag(it[1]), .flush(fl[1]), .out_valid(ov[1]),
    .out_data(od[1]), .out_tag(ot[1]));

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] bt(logic [127:0] s, int k);
    return s[127-8*k -: 8];
  endfunction
  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sbt[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  function automatic void expand(int i, logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nk, nr;
    nk = i ? 8 : 4;
    nr = i ? 14 : 10;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && j % nk == 4) t = subw(t);
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) krk[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] enc(int i, logic [127:0] pt);
    logic [127:0] s, t;
    int nr;
    nr = i ? 14 : 10;
    s = pt ^ krk[i][0];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[127-8*(4*c+q) -: 8] = sbt[bt(s, 4*((c+q)%4)+q)];
      s = t;
      if (r < nr)
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++)
            t[127-8*(4*c+q) -: 8] = xt(bt(s, 4*c+q)) ^ xt(bt(s, 4*c+(q+1)%4)) ^ bt(s, 4*c+(q+1)%4) ^
                                    bt(s, 4*c+(q+2)%4) ^ bt(s, 4*c+(q+3)%4);
      s = t ^ krk[i][r];
    end
    return s;
  endfunction

  task automatic chk(string tag, int i, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s d%0d: got %h want %h", tag, i, got, exp);
    end
  endtask

  // cycle-level model: key readiness, key_err, in-flight blocks with their due cycle
  always @(negedge clk) begin
    int nr;
    bit busy, exo;
    ent_t e;
    for (int i = 0; i < 2; i++) begin
      nr = i ? 14 : 10;
      while (sb[i].size() != 0 && sb[i][0].due < cyc) void'(sb[i].pop_front());
      busy = sb[i].size() != 0;
      exo = busy && sb[i][0].due == cyc;
      chk("out_valid", i, 128'(ov[i]), 128'(exo));
      if (exo) begin
        e = sb[i].pop_front();
        chk("out_data", i, od[i], e.pt);
        chk("out_tag", i, 128'(ot[i]), 128'(e.tag));
      end
      chk("key_ready", i, 128'(kr[i]), 128'(mready[i]));
      chk("in_ready", i, 128'(ir[i]), 128'(mready[i] & !ks[i]));
      chk("key_err", i, 128'(ke[i]), 128'(merr[i]));
      if (!rst) begin
        sb[i].delete();
        mready[i] = 0;
        loading[i] = 0;
        merr[i] = 0;
      end else begin
        merr[i] = ks[i] && busy;
        if (mready[i] && !ks[i] && iv[i]) sb[i].push_back('{cur_pt[i], it[i], cyc + nr + 1});
        if (fl[i]) sb[i].delete();
        if (ks[i] && !busy) begin
          loading[i] = 1;
          beats[i] = 0;
          mready[i] = 0;
        end else if (loading[i] && rv[i]) begin
          beats[i]++;
          if (beats[i] == nr + 1) begin
            loading[i] = 0;
            mready[i] = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(int i, logic [255:0] key, bit gaps);
    int nr;
    nr = i ? 14 : 10;
    expand(i, key);
    ks[i] = 1;
    step();
    ks[i] = 0;
    for (int r = 0; r <= nr; r++) begin
      if (gaps && $urandom_range(0, 1) != 0) step();
      rv[i] = 1;
      rd[i] = krk[i][r];
      step();
      rv[i] = 0;
    end
    chk("loaded_key_ready", i, 128'(kr[i]), 128'd1);
  endtask

  task automatic send(int i, logic [127:0] pt, logic [127:0] ct, logic [3:0] tag);
    iv[i] = 1;
    id[i] = ct;
    it[i] = tag;
    cur_pt[i] = pt;
    step();
    iv[i] = 0;
  endtask

  task automatic send_rnd(int i, logic [3:0] tag);
    logic [127:0] p;
    p = rnd128();
    send(i, p, enc(i, p), tag);
  endtask

  task automatic drain(int i);
    for (int k = 0; k < 40 && sb[i].size() != 0; k++) step();
    chk("drain", i, 128'(sb[i].size()), 128'd0);
  endtask

  initial begin
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      ks[i] = 0; rv[i] = 0; iv[i] = 0; fl[i] = 0;
      rd[i] = '0; id[i] = '0; it[i] = '0; cur_pt[i] = '0;
    end
    build_sbox();
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, 128'(ov[i]), 128'd0);
      chk("rst_out_data", i, od[i], 128'd0);
      chk("rst_out_tag", i, 128'(ot[i]), 128'd0);
      chk("rst_key_ready", i, 128'(kr[i]), 128'd0);
    end
    rst = 1;
    step();
    // AES-256 known answer, then random blocks
    load_keys(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0);
    send(1, 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 4'h5);
    for (int k = 0; k < 6; k++) send_rnd(1, 4'(k));
    drain(1);
    // AES-128 known answer with gapped key beats
    load_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1);
    send(0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h3);
    drain(0);
    for (int k = 0; k < 20; k++) send_rnd(0, 4'(k % 16));
    drain(0);
    for (int k = 0; k < 16; k++)
      if ($urandom_range(0, 2) == 0) step();
      else send_rnd(0, 4'(k));
    drain(0);
    // key_start with blocks in flight, colliding with an in_valid
    for (int k = 0; k < 3; k++) send_rnd(0, 4'(k + 8));
    ks[0] = 1;
    iv[0] = 1;
    id[0] = rnd128();
    step();
    ks[0] = 0;
    iv[0] = 0;
    chk("busy_key_err", 0, 128'(ke[0]), 128'd1);
    chk("busy_key_ready", 0, 128'(kr[0]), 128'd1);
    drain(0);
    load_keys(0, {rnd128(), 128'h0}, 1);
    for (int k = 0; k < 5; k++) send_rnd(0, 4'(k));
    drain(0);
    // flush with 5 in flight plus one accepted on the flush edge
    for (int k = 0; k < 5; k++) send_rnd(0, 4'(k));
    fl[0] = 1;
    iv[0] = 1;
    id[0] = rnd128();
    step();
    fl[0] = 0;
    iv[0] = 0;
    chk("flush_out_valid", 0, 128'(ov[0]), 128'd0);
    send_rnd(0, 4'hc);
    drain(0);
    // reset mid-stream
    for (int k = 0; k < 4; k++) send_rnd(0, 4'(k));
    rst = 0;
    iv[0] = 1;
    step();
    chk("mid_rst_out_valid", 0, 128'(ov[0]), 128'd0);
    chk("mid_rst_key_ready", 0, 128'(kr[0]), 128'd0);
    chk("mid_rst_in_ready", 0, 128'(ir[0]), 128'd0);
    chk("mid_rst_out_data", 0, od[0], 128'd0);
    rst = 1;
    repeat (5) step();
    iv[0] = 0;
    load_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0);
    send(0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h9);
    drain(0);
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
